// File: rtl/div_seq_pkg.sv
// rtl/div_seq_pkg.sv - shared EX-stage defines: divider state encodings, result width, div aluops
package div_seq_pkg;

    localparam int REG_DATA_WIDTH   = 32;
    localparam int DIV_RESULT_WIDTH = 2 * REG_DATA_WIDTH;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    typedef enum logic [1:0] {
        DIV_IDLE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_RUN     = 2'b10,
        DIV_DONE    = 2'b11
    } div_state_e;

endpackage

// File: rtl/div_seq.sv
// rtl/div_seq.sv - radix-2 restoring signed/unsigned divider for the EX stage (option: DIV_ZERO_FLAG_EN)
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                signed_div,
    input  logic [DATA_W-1:0]   op1,
    input  logic [DATA_W-1:0]   op2,
    input  logic                annul,
`ifdef DIV_ZERO_FLAG_EN
    output logic                div_zero,
`endif
    output logic [2*DATA_W-1:0] result,
    output logic                ready,
    output logic                busy
);

    div_state_e state, state_nxt;

    logic [CNT_W-1:0]    cnt;
    logic [2*DATA_W:0]   work;
    logic [DATA_W-1:0]   divisor;
    logic                q_neg;
    logic                r_neg;

    logic                op1_neg, op2_neg;
    logic [DATA_W-1:0]   op1_abs, op2_abs;
    logic [2*DATA_W:0]   shifted;
    logic [DATA_W:0]     trial;
    logic [2*DATA_W:0]   work_nxt;
    logic [DATA_W-1:0]   quot_raw, rem_raw, quot_fix, rem_fix;
    logic                last;
    logic                accept;

    assign accept  = start & ~annul;
    assign op1_neg = signed_div & op1[DATA_W-1];
    assign op2_neg = signed_div & op2[DATA_W-1];
    assign op1_abs = op1_neg ? (~op1 + 1'b1) : op1;
    assign op2_abs = op2_neg ? (~op2 + 1'b1) : op2;

    // One restoring step: shift, then trial-subtract the divisor from the upper DATA_W+1 bits.
    assign shifted  = {work[2*DATA_W-1:0], 1'b0};
    assign trial    = shifted[2*DATA_W:DATA_W] - {1'b0, divisor};
    assign work_nxt = trial[DATA_W] ? shifted : {trial, shifted[DATA_W-1:1], 1'b1};
    assign quot_raw = work_nxt[DATA_W-1:0];
    assign rem_raw  = work_nxt[2*DATA_W-1:DATA_W];
    assign quot_fix = q_neg ? (~quot_raw + 1'b1) : quot_raw;
    assign rem_fix  = r_neg ? (~rem_raw + 1'b1) : rem_raw;
    assign last     = (cnt == CNT_W'(DATA_W - 1));

    assign ready = (state == DIV_DONE);
    assign busy  = ((state == DIV_IDLE) & accept) | (state == DIV_BY_ZERO) | (state == DIV_RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= DIV_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE:    if (accept) state_nxt = (op2 == '0) ? DIV_BY_ZERO : DIV_RUN;
            DIV_BY_ZERO: state_nxt = annul ? DIV_IDLE : DIV_DONE;
            DIV_RUN:     state_nxt = annul ? DIV_IDLE : (last ? DIV_DONE : DIV_RUN);
            DIV_DONE:    if (annul || !start) state_nxt = DIV_IDLE;
            default:     state_nxt = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            work    <= '0;
            divisor <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            result  <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (accept && op2 != '0) begin
                        q_neg   <= op1_neg ^ op2_neg;
                        r_neg   <= op1_neg;
                        divisor <= op2_abs;
                        work    <= {{(DATA_W+1){1'b0}}, op1_abs};
                        cnt     <= '0;
                    end
                end
                DIV_BY_ZERO: begin
                    if (!annul) result <= '0;
                end
                DIV_RUN: begin
                    if (!annul) begin
                        work <= work_nxt;
                        cnt  <= cnt + 1'b1;
                        if (last) result <= {rem_fix, quot_fix};
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DIV_ZERO_FLAG_EN
    // Flag follows the divide-by-zero path only: set entering BY_ZERO, kept while it lands in DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) div_zero <= 1'b0;
        else        div_zero <= (state_nxt == DIV_BY_ZERO) | (div_zero & (state_nxt == DIV_DONE));
    end
`endif

endmodule
